audio_out_interface: RTL and testbench
======================================

// Module: audio_out_interface
// PURPOSE
//  Avalon-MM slave that accepts audio samples written by the CPU, buffers them
//  in a DEPTH-entry FIFO and streams them to the output shifter over a
//  valid/ready handshake. Transmit-side counterpart of the capture driver
//  interface. A level IRQ asks the CPU for more samples when the FIFO runs low.
// PARAMETERS
//  DATA_SIZE  28  sample width in bits (1..32)
//  DEPTH      16  FIFO entries; power of 2, 2..128
// PORTS
//  clk           in   1          50 MHz system clock
//  rst           in   1          async reset, active-low
//  chipselect    in   1          bus select
//  address       in   2          register select
//  read          in   1          bus read strobe
//  write         in   1          bus write strobe
//  writedata     in   32         bus write data
//  read_data     out  32         bus read data, registered
//  irq           out  1          low-watermark interrupt, level
//  source_valid  out  1          sample available to shifter
//  source_data   out  DATA_SIZE  sample to shifter
//  source_ready  in   1          shifter accepts sample this cycle
// BEHAVIOUR
//  Reset (rst=0, async): FIFO emptied, pointers/count=0, overflow=underflow=0,
//   irq_en=0, threshold=DEPTH/2, read_data=0, irq=0, source_valid=0.
//   Mid-operation reset discards buffered samples; no partial transfer survives.
//  Register map (chipselect qualifies every access):
//   0 W: push writedata[DATA_SIZE-1:0]; R: returns 0
//   1 R: status {16'b0, level[7:0], 3'b0, irq_en, underflow, overflow, full, empty}
//     W: bit0 -> irq_en; bit1=1 clears overflow; bit2=1 clears underflow
//   2 R/W: threshold[7:0] (writes of values > DEPTH saturate to DEPTH)
//   3 R: DEPTH (constant); W: ignored
//  Bus read: read_data updated on the edge after chipselect&&read; 1-cycle
//   latency; holds last value otherwise. Same-cycle read and write of status
//   returns the pre-write value.
//  FIFO: first-word-fall-through. source_valid = !empty; source_data = head.
//   Push accepted iff !full (evaluated before any same-cycle pop); push on
//   full is dropped and sets sticky overflow. Pop on source_valid&&source_ready.
//   Simultaneous push+pop when neither full nor empty: level unchanged.
//   Pointers wrap modulo DEPTH; level range 0..DEPTH.
//  Write-to-output latency: sample written at edge N is on source_data with
//   source_valid=1 after edge N (FIFO previously empty).
//  Handshake: while source_valid && !source_ready, source_data stays stable.
//   source_ready while empty sets sticky underflow (shifter starved); no pop.
//  IRQ: registered; irq = irq_en && (level <= threshold), one cycle after
//   the level/enable change. Cleared only by refilling or clearing irq_en.
//  Sticky flag set and clear in the same cycle: set wins.
// TESTING
//  1 Reset, read addr1 -> read_data=0x0000_0001 (empty), irq=0, source_valid=0.
//  2 Write 0x0ABCDEF to addr0, source_ready=0 -> next cycle source_valid=1,
//    source_data=0x0ABCDEF, status level=1; hold 5 cycles, data stable.
//  3 Push 17 samples, DEPTH=16, no ready -> full=1, overflow=1, level=16;
//    drain with source_ready=1 -> 16 samples out in order, 17th absent.
//  4 threshold=4, irq_en=1, fill 8, drain with ready -> irq rises one cycle
//    after level reaches 4; push 1 more -> irq falls next cycle.
//  5 source_ready=1 with FIFO empty -> underflow=1; write 0x4 to addr1 -> 0.
//  6 Fill 10 samples, pull rst low mid-stream -> source_valid=0 immediately,
//    status after release = empty, level 0; continuous push+pop at full rate
//    with level 3 stays at 3 across pointer wrap.

Source files
------------

// File: rtl/audio_out_interface.sv
// ---------------------------------------------------------------------------
// audio_out_interface
// Avalon-MM slave that buffers CPU-written audio samples in a DEPTH-entry
// first-word-fall-through FIFO and streams them to the output shifter over a
// valid/ready handshake. A level interrupt requests more samples when the FIFO
// level drops to or below a programmable threshold.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-low
//   chipselect    bus select, qualifies every access
//   address[1:0]  register select (0 data, 1 status/ctrl, 2 threshold, 3 depth)
//   read, write   bus strobes
//   writedata     bus write data
//   read_data     registered bus read data (1-cycle latency, holds otherwise)
//   irq           registered low-watermark interrupt, level sensitive
//   source_valid  FIFO not empty
//   source_data   FIFO head sample
//   source_ready  shifter takes the head sample this cycle
// ---------------------------------------------------------------------------
module audio_out_interface #(
    parameter int DATA_SIZE = 28,
    parameter int DEPTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 chipselect,
    input  logic [1:0]           address,
    input  logic                 read,
    input  logic                 write,
    input  logic [31:0]          writedata,
    output logic [31:0]          read_data,
    output logic                 irq,
    output logic                 source_valid,
    output logic [DATA_SIZE-1:0] source_data,
    input  logic                 source_ready
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              LW      = AW + 1;
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [LW-1:0]   LVL_ONE = LW'(1);
    localparam logic [LW-1:0]   LVL_MAX = LW'(DEPTH);
    localparam logic [7:0]      DEPTH_B = 8'(DEPTH);
    localparam logic [31:0]     DEPTH_W = 32'(DEPTH);

    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 overflow_q, overflow_d;
    logic                 underflow_q, underflow_d;
    logic                 irq_en_q, irq_en_d;
    logic [7:0]           threshold_q, threshold_d;
    logic                 irq_q, irq_d;
    logic [31:0]          read_data_q, read_data_d;

    logic        empty_s, full_s;
    logic        push_req_s, push_s, pop_s;
    logic        ctrl_wr_s, thr_wr_s, rd_s;
    logic [31:0] status_s, rd_mux_s;
    logic        unused_ok_s;

    assign empty_s    = (level_q == {LW{1'b0}});
    assign full_s     = (level_q == LVL_MAX);
    assign push_req_s = chipselect && write && (address == 2'd0);
    // Fullness is judged on the current level, so a push on full is dropped
    // even when the shifter pops in the same cycle.
    assign push_s     = push_req_s && !full_s;
    assign pop_s      = !empty_s && source_ready;
    assign ctrl_wr_s  = chipselect && write && (address == 2'd1);
    assign thr_wr_s   = chipselect && write && (address == 2'd2);
    assign rd_s       = chipselect && read;
    assign status_s   = {16'h0000, 8'(level_q), 3'b000, irq_en_q, underflow_q,
                         overflow_q, full_s, empty_s};

    assign source_valid = !empty_s;
    assign source_data  = mem_q[rd_ptr_q];
    assign read_data    = read_data_q;
    assign irq          = irq_q;
    assign unused_ok_s  = ^writedata;

    // Next-state logic for FIFO bookkeeping, sticky flags, control and bus read.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
        rd_mux_s    = 32'h0000_0000;
        read_data_d = read_data_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase

        // Sticky flags: a set event in the same cycle as a clear wins.
        if (push_req_s && full_s) begin
            overflow_d = 1'b1;
        end else if (ctrl_wr_s && writedata[1]) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end

        if (source_ready && empty_s) begin
            underflow_d = 1'b1;
        end else if (ctrl_wr_s && writedata[2]) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end

        if (ctrl_wr_s) begin
            irq_en_d = writedata[0];
        end else begin
            irq_en_d = irq_en_q;
        end

        if (thr_wr_s) begin
            if (writedata[7:0] > DEPTH_B) begin
                threshold_d = DEPTH_B;
            end else begin
                threshold_d = writedata[7:0];
            end
        end else begin
            threshold_d = threshold_q;
        end

        // Status is sampled from current registers, so a same-cycle write to
        // the control register is not yet visible in the returned value.
        case (address)
            2'd0:    rd_mux_s = 32'h0000_0000;
            2'd1:    rd_mux_s = status_s;
            2'd2:    rd_mux_s = {24'h00_0000, threshold_q};
            2'd3:    rd_mux_s = DEPTH_W;
            default: rd_mux_s = 32'h0000_0000;
        endcase

        if (rd_s) begin
            read_data_d = rd_mux_s;
        end else begin
            read_data_d = read_data_q;
        end
    end

    // Interrupt request from the registered level, enable and threshold.
    always_comb begin
        irq_d = 1'b0;
        if (irq_en_q && (8'(level_q) <= threshold_q)) begin
            irq_d = 1'b1;
        end else begin
            irq_d = 1'b0;
        end
    end

    // Control/status state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= {AW{1'b0}};
            rd_ptr_q    <= {AW{1'b0}};
            level_q     <= {LW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            irq_en_q    <= 1'b0;
            threshold_q <= 8'(DEPTH / 2);
            irq_q       <= 1'b0;
            read_data_q <= 32'h0000_0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            irq_q       <= irq_d;
            read_data_q <= read_data_d;
        end
    end

    // Sample storage; contents are don't-care while the level marks them empty.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= writedata[DATA_SIZE-1:0];
        end
    end

endmodule

// File: tb/tb_audio_out_interface.sv
// Bench for audio_out_interface: directed scenarios plus random bus traffic,
// checked against a queue-level reference model and a sample scoreboard.
module tb_audio_out_interface;

    localparam int DS = 28;
    localparam int DP = 16;
    localparam int SB = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cs = 1'b0;
    logic [1:0]    address = 2'd0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [31:0]   wdata = 32'h0;
    logic [31:0]   read_data;
    logic          irq;
    logic          source_valid;
    logic [DS-1:0] source_data;
    logic          ready = 1'b0;

    audio_out_interface #(.DATA_SIZE(DS), .DEPTH(DP)) dut (
        .clk          (clk),
        .rst          (rst),
        .chipselect   (cs),
        .address      (address),
        .read         (rd),
        .write        (wr),
        .writedata    (wdata),
        .read_data    (read_data),
        .irq          (irq),
        .source_valid (source_valid),
        .source_data  (source_data),
        .source_ready (ready)
    );

    always #5 clk = ~clk;

    // Reference model state (written only by the model process).
    int          m_cnt = 0;
    int          m_thr = DP / 2;
    bit          m_of = 1'b0, m_uf = 1'b0, m_en = 1'b0, m_irq = 1'b0;
    logic [31:0] m_rd = 32'h0;
    logic [DS-1:0] exp_mem [SB];
    int          wr_cnt = 0;
    bit          m_push, m_pop, m_acc, m_ctrl, m_irq_n;

    // Monitor state.
    int rd_cnt = 0;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO seen as a count plus a list of accepted samples.
    initial begin
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_cnt = 0; m_thr = DP / 2; m_of = 1'b0; m_uf = 1'b0;
                m_en = 1'b0; m_irq = 1'b0; m_rd = 32'h0;
            end else begin
                m_irq_n = m_en && (m_cnt <= m_thr);
                if (cs && rd) begin
                    case (address)
                        2'd1: m_rd = {16'h0, 8'(m_cnt), 3'b000, m_en, m_uf, m_of,
                                      m_cnt == DP, m_cnt == 0};
                        2'd2: m_rd = 32'(m_thr);
                        2'd3: m_rd = 32'(DP);
                        default: m_rd = 32'h0;
                    endcase
                end
                m_push = cs && wr && (address == 2'd0);
                m_ctrl = cs && wr && (address == 2'd1);
                m_pop  = (m_cnt > 0) && ready;
                m_acc  = m_push && (m_cnt < DP);
                if (m_push && !m_acc) m_of = 1'b1;
                else if (m_ctrl && wdata[1]) m_of = 1'b0;
                if (ready && m_cnt == 0) m_uf = 1'b1;
                else if (m_ctrl && wdata[2]) m_uf = 1'b0;
                if (m_ctrl) m_en = wdata[0];
                if (cs && wr && address == 2'd2)
                    m_thr = (int'(wdata[7:0]) > DP) ? DP : int'(wdata[7:0]);
                if (m_acc) begin
                    exp_mem[wr_cnt % SB] = wdata[DS-1:0];
                    wr_cnt++;
                end
                m_cnt = m_cnt + int'(m_acc) - int'(m_pop);
                m_irq = m_irq_n;
            end
        end
    end

    // Monitor: compares outputs each falling edge, pops the sample scoreboard
    // whenever the DUT hands a sample to the shifter.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_valid", 32'(source_valid), 32'h0);
                chk("rst_irq", 32'(irq), 32'h0);
                chk("rst_read_data", read_data, 32'h0);
                rd_cnt = wr_cnt;
            end else begin
                chk("valid", 32'(source_valid), 32'(m_cnt != 0));
                chk("irq", 32'(irq), 32'(m_irq));
                chk("read_data", read_data, m_rd);
                if (source_valid && m_cnt != 0) begin
                    if (rd_cnt == wr_cnt) begin
                        chk("sb_underrun", 32'(rd_cnt), 32'(wr_cnt + 1));
                    end else begin
                        chk("source_data", 32'(source_data), 32'(exp_mem[rd_cnt % SB]));
                        if (ready) rd_cnt++;
                    end
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; address = a; wdata = d;
        cyc(1);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [1:0] a);
        cs = 1'b1; rd = 1'b1; address = a;
        cyc(1);
        cs = 1'b0; rd = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        bus_wr(2'd0, d);
    endtask

    initial begin
        rst = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(1);

        // Reset state and first status read.
        bus_rd(2'd1);
        bus_rd(2'd2);
        bus_rd(2'd3);
        cyc(1);

        // Single sample, held under back-pressure.
        ready = 1'b0;
        push(32'h00AB_CDEF);
        bus_rd(2'd1);
        cyc(5);
        ready = 1'b1;
        cyc(2);
        ready = 1'b0;

        // Overfill by one, then drain.
        for (int i = 0; i < 17; i++) push($urandom);
        bus_rd(2'd1);
        ready = 1'b1;
        cyc(20);
        ready = 1'b0;
        bus_rd(2'd1);
        bus_wr(2'd1, 32'h0000_0006);
        bus_rd(2'd1);

        // Low-watermark interrupt.
        bus_wr(2'd2, 32'h0000_0004);
        bus_wr(2'd1, 32'h0000_0001);
        for (int i = 0; i < 8; i++) push($urandom);
        ready = 1'b1;
        cyc(4);
        ready = 1'b0;
        cyc(3);
        push($urandom);
        cyc(3);
        ready = 1'b1;
        cyc(8);

        // Underflow while starved, then clear it.
        cyc(3);
        ready = 1'b0;
        bus_rd(2'd1);
        bus_wr(2'd1, 32'h0000_0004);
        bus_rd(2'd1);

        // Mid-stream reset.
        for (int i = 0; i < 10; i++) push($urandom);
        ready = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        ready = 1'b0;
        bus_rd(2'd1);

        // Level 3 held across pointer wrap by simultaneous push and pop.
        for (int i = 0; i < 3; i++) push($urandom);
        cs = 1'b1; wr = 1'b1; address = 2'd0; ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wdata = $urandom;
            cyc(1);
        end
        cs = 1'b0; wr = 1'b0; ready = 1'b0;
        bus_rd(2'd1);

        // Threshold saturation and read-only registers.
        bus_wr(2'd2, 32'h0000_00C8);
        bus_rd(2'd2);
        bus_wr(2'd3, 32'h0000_0055);
        bus_rd(2'd3);
        bus_rd(2'd0);

        // Random bus and shifter traffic.
        for (int i = 0; i < 600; i++) begin
            cs      = ($urandom_range(0, 3) != 0);
            rd      = ($urandom_range(0, 1) != 0);
            wr      = ($urandom_range(0, 2) != 0);
            address = 2'($urandom_range(0, 3));
            wdata   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            ready   = ($urandom_range(0, 2) == 0);
            cyc(1);
        end
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        ready = 1'b1;
        cyc(DP + 4);
        ready = 1'b0;
        bus_rd(2'd1);
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
